// File: rtl/game_pkg.sv
// Shared types and rule constants for the
// cellular-automaton step engine.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    COMMIT
  } state_t;

  localparam logic [8:0] CONWAY_BIRTH   = 9'h008;
  localparam logic [8:0] CONWAY_SURVIVE = 9'h00C;

endpackage

// File: rtl/game_rule_cell.sv
// Next-state rule for a single cell from its
// 8 neighbours and the birth/survive masks.
module game_rule_cell
  import game_pkg::*;
(
  input  logic [7:0] nbr,
  input  logic       alive,
  input  logic [8:0] birth_mask,
  input  logic [8:0] survive_mask,
  output logic       next
);

  logic [3:0] n;

  always_comb begin
    n = '0;
    for (int i = 0; i < 8; i++)
      n = n + {3'b000, nbr[i]};
  end

  assign next = alive ? survive_mask[n]
                      : birth_mask[n];

endmodule

// File: rtl/game_step_engine.sv
// One-generation step engine: evaluates one
// full row per cycle from a snapshot field.
module game_step_engine
  import game_pkg::*;
#(
  parameter  int W    = 40,
  parameter  int H    = 30,
  parameter  int WRAP = 1,
  localparam int PW   = $clog2(W*H+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [H-1:0][W-1:0]   field_in,
  input  logic [8:0]            birth_mask,
  input  logic [8:0]            survive_mask,
  output logic                  busy,
  output logic                  done,
  output logic [H-1:0][W-1:0]   field_out,
  output logic [PW-1:0]         pop_count,
  output logic [15:0]           gen_count
);

  localparam int   RW   = $clog2(H);
  localparam logic EDGE = (WRAP != 0);

  state_t               state;
  logic [RW-1:0]        row;
  logic [H-1:0][W-1:0]  snap;
  logic [H-1:0][W-1:0]  next_buf;
  logic [8:0]           birth_q;
  logic [8:0]           survive_q;
  logic [PW-1:0]        sum;

  logic [W-1:0]   up, mid, dn;
  logic [W+1:0]   upx, midx, dnx;
  logic [W-1:0]   row_next;
  logic [PW-1:0]  row_pop;

  // Rows above/below; off-field rows read dead
  // unless the field is toroidal.
  always_comb begin
    mid = snap[row];
    if (row == '0)
      up = EDGE ? snap[H-1] : '0;
    else
      up = snap[row - 1'b1];
    if (row == RW'(H-1))
      dn = EDGE ? snap[0] : '0;
    else
      dn = snap[row + 1'b1];
  end

  // Pad each row with its wrap/dead column so
  // column x sees [x] left, [x+1] self, [x+2] right.
  assign upx  = {up[0]  & EDGE, up,
                 up[W-1]  & EDGE};
  assign midx = {mid[0] & EDGE, mid,
                 mid[W-1] & EDGE};
  assign dnx  = {dn[0]  & EDGE, dn,
                 dn[W-1]  & EDGE};

  for (genvar x = 0; x < W; x++) begin : g_cell
    game_rule_cell u_cell (
      .nbr          ({upx[x], upx[x+1], upx[x+2],
                      midx[x], midx[x+2],
                      dnx[x], dnx[x+1], dnx[x+2]}),
      .alive        (midx[x+1]),
      .birth_mask   (birth_q),
      .survive_mask (survive_q),
      .next         (row_next[x])
    );
  end

  always_comb begin
    row_pop = '0;
    for (int i = 0; i < W; i++)
      row_pop = row_pop + PW'(row_next[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      row       <= '0;
      snap      <= '0;
      next_buf  <= '0;
      birth_q   <= '0;
      survive_q <= '0;
      sum       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      field_out <= '0;
      pop_count <= '0;
      gen_count <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            snap      <= field_in;
            birth_q   <= birth_mask;
            survive_q <= survive_mask;
            row       <= '0;
            sum       <= '0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          next_buf[row] <= row_next;
          sum           <= sum + row_pop;
          if (row == RW'(H-1))
            state <= COMMIT;
          else
            row <= row + 1'b1;
        end
        COMMIT: begin
          field_out <= next_buf;
          pop_count <= sum;
          gen_count <= gen_count + 16'd1;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_step_engine.sv
// Randomised bench for game_step_engine: toroidal
// and bounded instances against a behavioural model.
module tb_game_step_engine;
  import game_pkg::*;

  localparam int W  = 40;
  localparam int H  = 30;
  localparam int PW = $clog2(W*H+1);

  typedef logic [H-1:0][W-1:0] field_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  field_t        field_in;
  logic [8:0]    birth_mask;
  logic [8:0]    survive_mask;
  logic          busy1, done1, busy0, done0;
  field_t        fo1, fo0;
  logic [PW-1:0] pop1, pop0;
  logic [15:0]   gen1, gen0;

  int total = 0;
  int bad   = 0;
  int gen_exp = 0;

  always #5 clk = ~clk;

  game_step_engine #(.W(W), .H(H), .WRAP(1)) dut1 (
    .clk(clk), .rst(rst), .start(start),
    .field_in(field_in), .birth_mask(birth_mask),
    .survive_mask(survive_mask), .busy(busy1),
    .done(done1), .field_out(fo1),
    .pop_count(pop1), .gen_count(gen1)
  );

  game_step_engine #(.W(W), .H(H), .WRAP(0)) dut0 (
    .clk(clk), .rst(rst), .start(start),
    .field_in(field_in), .birth_mask(birth_mask),
    .survive_mask(survive_mask), .busy(busy0),
    .done(done0), .field_out(fo0),
    .pop_count(pop0), .gen_count(gen0)
  );

  function automatic field_t rand_field(int dens);
    field_t f;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        f[y][x] = (int'($urandom_range(99)) < dens);
    return f;
  endfunction

  function automatic int popcnt(field_t f);
    int c;
    c = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        c += int'(f[y][x]);
    return c;
  endfunction

  function automatic field_t model_step(field_t f,
      logic [8:0] b, logic [8:0] s, bit wrap);
    field_t r;
    int n, yy, xx;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        n = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++) begin
            yy = y + dy;
            xx = x + dx;
            if (wrap) begin
              yy = (yy + H) % H;
              xx = (xx + W) % W;
            end
            if (!(dy == 0 && dx == 0) &&
                yy >= 0 && yy < H &&
                xx >= 0 && xx < W)
              n += int'(f[yy][xx]);
          end
        r[y][x] = f[y][x] ? s[n] : b[n];
      end
    return r;
  endfunction

  function automatic field_t glider(int ox, int oy);
    field_t f;
    f = '0;
    f[(oy+0+H)%H][(ox+1+W)%W] = 1'b1;
    f[(oy+1+H)%H][(ox+2+W)%W] = 1'b1;
    f[(oy+2+H)%H][(ox+0+W)%W] = 1'b1;
    f[(oy+2+H)%H][(ox+1+W)%W] = 1'b1;
    f[(oy+2+H)%H][(ox+2+W)%W] = 1'b1;
    return f;
  endfunction

  function automatic int diff_row(field_t a, field_t b);
    for (int y = 0; y < H; y++)
      if (a[y] !== b[y]) return y;
    return 0;
  endfunction

  // Launch one step, scramble inputs and poke start
  // while it runs (up to the commit edge), then stop
  // in the cycle done is observed or at the bound.
  task automatic run_step(input field_t f,
      input logic [8:0] b, input logic [8:0] s,
      output int lat, output logic bsy);
    @(posedge clk); #1;
    field_in = f;
    birth_mask = b;
    survive_mask = s;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bsy = busy1 & busy0;
    lat = 0;
    while (done1 !== 1'b1 && lat < 200) begin
      field_in = rand_field(50);
      birth_mask = 9'($urandom);
      survive_mask = 9'($urandom);
      start = (lat <= H) ? 1'($urandom) : 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (busy1 !== 1'b0 || busy0 !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy got=%b%b exp=00",
               busy1, busy0);
    end
    total++;
    if (done1 !== 1'b0 || done0 !== 1'b0) begin
      bad++;
      $display("FAIL reset_done got=%b%b exp=00",
               done1, done0);
    end
    total++;
    if (fo1 !== '0 || fo0 !== '0) begin
      bad++;
      $display("FAIL reset_field got=%0d/%0d exp=0",
               popcnt(fo1), popcnt(fo0));
    end
    total++;
    if (pop1 !== '0 || gen1 !== '0) begin
      bad++;
      $display("FAIL reset_counts got=%0d/%0d exp=0/0",
               pop1, gen1);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (busy1 !== 1'b0 || gen1 !== 16'd0) begin
      bad++;
      $display("FAIL idle_after_reset got=%b/%0d exp=0/0",
               busy1, gen1);
    end
  endtask

  task automatic test_blinker();
    field_t f, e;
    int lat;
    logic bsy;
    int r;
    f = '0;
    f[10][5] = 1'b1; f[10][6] = 1'b1; f[10][7] = 1'b1;
    e = '0;
    e[9][6] = 1'b1; e[10][6] = 1'b1; e[11][6] = 1'b1;
    run_step(f, CONWAY_BIRTH, CONWAY_SURVIVE, lat, bsy);
    gen_exp++;
    total++;
    if (lat != H + 1) begin
      bad++;
      $display("FAIL blinker_latency got=%0d exp=%0d",
               lat, H + 1);
    end
    total++;
    if (bsy !== 1'b1) begin
      bad++;
      $display("FAIL busy_on_accept got=%b exp=1", bsy);
    end
    total++;
    if (fo1 !== e || fo0 !== e) begin
      bad++;
      r = diff_row(fo1, e);
      $display("FAIL blinker_field row=%0d got=%h exp=%h",
               r, fo1[r], e[r]);
    end
    total++;
    if (pop1 !== PW'(3) || pop0 !== PW'(3)) begin
      bad++;
      $display("FAIL blinker_pop got=%0d/%0d exp=3",
               pop1, pop0);
    end
    total++;
    if (gen1 !== 16'(gen_exp) || done0 !== 1'b1) begin
      bad++;
      $display("FAIL blinker_gen got=%0d exp=%0d",
               gen1, gen_exp);
    end
    total++;
    if (busy1 !== 1'b0) begin
      bad++;
      $display("FAIL busy_at_done got=%b exp=0", busy1);
    end
    @(posedge clk); #1;
    total++;
    if (done1 !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse got=%b exp=0", done1);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (fo1 !== e || pop1 !== PW'(3) ||
        gen1 !== 16'(gen_exp)) begin
      bad++;
      $display("FAIL hold got=%0d/%0d exp=3/%0d",
               pop1, gen1, gen_exp);
    end
  endtask

  task automatic test_glider();
    field_t f, e1, e0, g;
    int lat;
    logic bsy;
    int r;
    f = glider(-1, -1);
    for (int k = 0; k < 4; k++) begin
      e1 = model_step(f, CONWAY_BIRTH,
                      CONWAY_SURVIVE, 1'b1);
      e0 = model_step(f, CONWAY_BIRTH,
                      CONWAY_SURVIVE, 1'b0);
      run_step(f, CONWAY_BIRTH, CONWAY_SURVIVE,
               lat, bsy);
      gen_exp++;
      total++;
      if (fo1 !== e1) begin
        bad++;
        r = diff_row(fo1, e1);
        $display("FAIL glider_wrap k=%0d row=%0d got=%h exp=%h",
                 k, r, fo1[r], e1[r]);
      end
      total++;
      if (fo0 !== e0) begin
        bad++;
        r = diff_row(fo0, e0);
        $display("FAIL glider_nowrap k=%0d row=%0d got=%h exp=%h",
                 k, r, fo0[r], e0[r]);
      end
      total++;
      if (pop1 !== PW'(5)) begin
        bad++;
        $display("FAIL glider_pop k=%0d got=%0d exp=5",
                 k, pop1);
      end
      f = fo1;
    end
    g = glider(0, 0);
    total++;
    if (fo1 !== g) begin
      bad++;
      r = diff_row(fo1, g);
      $display("FAIL glider_shift row=%0d got=%h exp=%h",
               r, fo1[r], g[r]);
    end
  endtask

  task automatic test_wrap0_block();
    field_t f, e0, e1;
    int lat;
    logic bsy;
    int r;
    f = '0;
    f[28][38] = 1'b1; f[28][39] = 1'b1;
    f[29][38] = 1'b1; f[29][39] = 1'b1;
    f[0][0] = 1'b1;
    e0 = f;
    e0[0][0] = 1'b0;
    e1 = model_step(f, CONWAY_BIRTH,
                    CONWAY_SURVIVE, 1'b1);
    run_step(f, CONWAY_BIRTH, CONWAY_SURVIVE, lat, bsy);
    gen_exp++;
    total++;
    if (fo0 !== e0) begin
      bad++;
      r = diff_row(fo0, e0);
      $display("FAIL block_nowrap row=%0d got=%h exp=%h",
               r, fo0[r], e0[r]);
    end
    total++;
    if (pop0 !== PW'(4)) begin
      bad++;
      $display("FAIL block_pop got=%0d exp=4", pop0);
    end
    total++;
    if (fo1 !== e1 || pop1 !== PW'(popcnt(e1))) begin
      bad++;
      r = diff_row(fo1, e1);
      $display("FAIL block_wrap row=%0d got=%h exp=%h",
               r, fo1[r], e1[r]);
    end
  endtask

  task automatic test_random();
    field_t f, e1, e0;
    logic [8:0] b, s;
    int lat;
    logic bsy;
    int r;
    for (int k = 0; k < 6; k++) begin
      f = rand_field(int'($urandom_range(10, 70)));
      b = 9'($urandom);
      s = 9'($urandom);
      if (k < 2) begin
        b = CONWAY_BIRTH;
        s = CONWAY_SURVIVE;
      end
      e1 = model_step(f, b, s, 1'b1);
      e0 = model_step(f, b, s, 1'b0);
      run_step(f, b, s, lat, bsy);
      gen_exp++;
      total++;
      if (lat != H + 1) begin
        bad++;
        $display("FAIL rand_latency k=%0d got=%0d exp=%0d",
                 k, lat, H + 1);
      end
      total++;
      if (fo1 !== e1) begin
        bad++;
        r = diff_row(fo1, e1);
        $display("FAIL rand_wrap k=%0d row=%0d got=%h exp=%h",
                 k, r, fo1[r], e1[r]);
      end
      total++;
      if (fo0 !== e0) begin
        bad++;
        r = diff_row(fo0, e0);
        $display("FAIL rand_nowrap k=%0d row=%0d got=%h exp=%h",
                 k, r, fo0[r], e0[r]);
      end
      total++;
      if (pop1 !== PW'(popcnt(e1)) ||
          pop0 !== PW'(popcnt(e0))) begin
        bad++;
        $display("FAIL rand_pop k=%0d got=%0d/%0d exp=%0d/%0d",
                 k, pop1, pop0, popcnt(e1), popcnt(e0));
      end
      total++;
      if (gen1 !== 16'(gen_exp) ||
          gen0 !== 16'(gen_exp)) begin
        bad++;
        $display("FAIL rand_gen k=%0d got=%0d/%0d exp=%0d",
                 k, gen1, gen0, gen_exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    field_t f, g, ef, eg;
    int lat;
    logic bsy;
    int r;
    f = rand_field(35);
    g = rand_field(35);
    ef = model_step(f, CONWAY_BIRTH, CONWAY_SURVIVE, 1'b1);
    eg = model_step(g, CONWAY_BIRTH, CONWAY_SURVIVE, 1'b1);
    run_step(f, CONWAY_BIRTH, CONWAY_SURVIVE, lat, bsy);
    gen_exp++;
    total++;
    if (fo1 !== ef) begin
      bad++;
      r = diff_row(fo1, ef);
      $display("FAIL b2b_first row=%0d got=%h exp=%h",
               r, fo1[r], ef[r]);
    end
    field_in = g;
    birth_mask = CONWAY_BIRTH;
    survive_mask = CONWAY_SURVIVE;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (busy1 !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept got=%b exp=1", busy1);
    end
    lat = 0;
    while (done1 !== 1'b1 && lat < 200) begin
      field_in = rand_field(50);
      start = (lat == H);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    gen_exp++;
    total++;
    if (lat != H + 1) begin
      bad++;
      $display("FAIL b2b_latency got=%0d exp=%0d",
               lat, H + 1);
    end
    total++;
    if (fo1 !== eg || pop1 !== PW'(popcnt(eg))) begin
      bad++;
      r = diff_row(fo1, eg);
      $display("FAIL b2b_second row=%0d got=%h exp=%h",
               r, fo1[r], eg[r]);
    end
    total++;
    if (gen1 !== 16'(gen_exp)) begin
      bad++;
      $display("FAIL b2b_gen got=%0d exp=%0d",
               gen1, gen_exp);
    end
    @(posedge clk); #1;
    total++;
    if (busy1 !== 1'b0) begin
      bad++;
      $display("FAIL commit_start_ignored got=%b exp=0",
               busy1);
    end
  endtask

  task automatic test_zero_masks();
    field_t f;
    int lat;
    logic bsy;
    f = '1;
    run_step(f, 9'h000, 9'h000, lat, bsy);
    gen_exp++;
    total++;
    if (fo1 !== '0 || fo0 !== '0) begin
      bad++;
      $display("FAIL zero_mask_field got=%0d/%0d exp=0",
               popcnt(fo1), popcnt(fo0));
    end
    total++;
    if (pop1 !== '0 || pop0 !== '0) begin
      bad++;
      $display("FAIL zero_mask_pop got=%0d/%0d exp=0",
               pop1, pop0);
    end
  endtask

  task automatic test_reset_mid_run();
    field_t f, e;
    int lat;
    int seen;
    int r;
    f = rand_field(40);
    @(posedge clk); #1;
    field_in = f;
    birth_mask = CONWAY_BIRTH;
    survive_mask = CONWAY_SURVIVE;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    gen_exp = 0;
    total++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      bad++;
      $display("FAIL abort_flags got=%b%b exp=00",
               busy1, done1);
    end
    total++;
    if (fo1 !== '0 || pop1 !== '0) begin
      bad++;
      $display("FAIL abort_field got=%0d/%0d exp=0/0",
               popcnt(fo1), pop1);
    end
    total++;
    if (gen1 !== 16'd0 || gen0 !== 16'd0) begin
      bad++;
      $display("FAIL abort_gen got=%0d/%0d exp=0",
               gen1, gen0);
    end
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done1 === 1'b1) seen++;
    end
    f = rand_field(40);
    e = model_step(f, CONWAY_BIRTH, CONWAY_SURVIVE, 1'b1);
    rst = 1'b0;
    field_in = f;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (busy1 !== 1'b1) begin
      bad++;
      $display("FAIL first_cycle_accept got=%b exp=1",
               busy1);
    end
    lat = 0;
    while (done1 !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    gen_exp++;
    total++;
    if (seen != 0 || lat != H + 1) begin
      bad++;
      $display("FAIL abort_restart got=%0d/%0d exp=0/%0d",
               seen, lat, H + 1);
    end
    total++;
    if (fo1 !== e || gen1 !== 16'(gen_exp)) begin
      bad++;
      r = diff_row(fo1, e);
      $display("FAIL restart_field row=%0d got=%h exp=%h gen=%0d",
               r, fo1[r], e[r], gen1);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    field_in = '0;
    birth_mask = '0;
    survive_mask = '0;
    test_reset();
    test_blinker();
    test_glider();
    test_wrap0_block();
    test_random();
    test_back_to_back();
    test_zero_masks();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
